mod7_seq_monitor: RTL and testbench

MOD7_SEQ_MONITOR -- requirements
Module: mod7_seq_monitor

---
 rtl/mod7Counter_pkg.sv | 18 +
 rtl/mod7_seq_monitor_event_counter.sv | 36 +++
 rtl/mod7_seq_monitor.sv | 128 ++++++++++++
 tb/tb_mod7_seq_monitor.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mod7Counter_pkg.sv
// Shared types and constants for the modulo-7 sequence monitor.
// Imported by the monitor top and its event counter.
package mod7Counter_pkg;

  localparam int MOD7_MODULUS = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_t;

endpackage

// File: rtl/mod7_seq_monitor_event_counter.sv
// Event counter shared by the wrap and error tallies.
// MODE picks wrap-around or saturate-at-all-ones behaviour.
module event_counter
  import mod7Counter_pkg::*;
#(
  parameter int        W    = 8,
  parameter cnt_mode_t MODE = CNT_WRAP
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = W'(1);

  logic at_max;

  assign at_max = (cnt == '1);

  // clear wins over hold; clear with a new event restarts at one
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? ONE : '0;
    end else if (inc) begin
      if (MODE == CNT_SAT && at_max)
        cnt <= cnt;
      else
        cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/mod7_seq_monitor.sv
// Watches a modulo-N up-counter, tracks sync, counts wraps and errors.
// All outputs are registered, one cycle after the sampled edge.
module mod7_seq_monitor
  import mod7Counter_pkg::*;
#(
  parameter int MODULUS = MOD7_MODULUS,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count_in,
  input  logic             count_en,
  input  logic             clr_err,
  output logic             in_sync,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic             wrap_ovf,
  output logic             seq_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] MOD_V  = CNT_W'(MODULUS);
  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(MODULUS - 1);
  localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

  state_t           state;
  state_t           nxt_state;
  logic [CNT_W-1:0] exp;
  logic [CNT_W-1:0] nxt_exp;
  logic             err_evt;
  logic             wrap_evt;

  function automatic logic [CNT_W-1:0] adv(
    input logic [CNT_W-1:0] v
  );
    return (v == LAST_V) ? '0 : v + ONE_V;
  endfunction

  // next-state decode and event detection for the current sample
  always_comb begin
    nxt_state = state;
    nxt_exp   = exp;
    err_evt   = 1'b0;
    wrap_evt  = 1'b0;
    if (count_en) begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            (count_in == '0): begin
              nxt_state = TRACK;
              nxt_exp   = adv('0);
            end
            (count_in >= MOD_V): begin
              nxt_state = FAULT;
              err_evt   = 1'b1;
            end
            default: ;
          endcase
        end
        TRACK: begin
          if (count_in == exp) begin
            nxt_exp  = adv(exp);
            wrap_evt = (count_in == '0);
          end else begin
            nxt_state = FAULT;
            err_evt   = 1'b1;
          end
        end
        FAULT: begin
          if (count_in == '0) begin
            nxt_state = TRACK;
            nxt_exp   = adv('0);
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_exp   = '0;
        end
      endcase
    end
  end

  // FSM state plus registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      exp        <= '0;
      in_sync    <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_ovf   <= 1'b0;
      seq_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state      <= nxt_state;
      exp        <= nxt_exp;
      in_sync    <= (nxt_state == TRACK);
      wrap_pulse <= wrap_evt;
      seq_err    <= err_evt;
      err_sticky <= err_evt | (err_sticky & ~clr_err);
      wrap_ovf   <= wrap_ovf
                  | (wrap_evt & (wrap_cnt == '1));
    end
  end

  event_counter #(
    .W    (CNT_W),
    .MODE (CNT_WRAP)
  ) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (wrap_evt),
    .cnt   (wrap_cnt)
  );

  event_counter #(
    .W    (CNT_W),
    .MODE (CNT_SAT)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_err),
    .inc   (err_evt),
    .cnt   (err_cnt)
  );

endmodule

// File: tb/tb_mod7_seq_monitor.sv
// Scoreboard bench for mod7_seq_monitor.
// Directed vectors push expectations; a negedge monitor pops and checks.
module tb_mod7_seq_monitor;

  typedef struct packed {
    logic       is;
    logic       wp;
    logic [7:0] wc;
    logic       wo;
    logic       se;
    logic       es;
    logic [7:0] ec;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] count_in;
  logic       count_en;
  logic       clr_err;
  logic       in_sync;
  logic       wrap_pulse;
  logic [7:0] wrap_cnt;
  logic       wrap_ovf;
  logic       seq_err;
  logic       err_sticky;
  logic [7:0] err_cnt;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  mod7_seq_monitor #(
    .MODULUS (7),
    .CNT_W   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count_in),
    .count_en   (count_en),
    .clr_err    (clr_err),
    .in_sync    (in_sync),
    .wrap_pulse (wrap_pulse),
    .wrap_cnt   (wrap_cnt),
    .wrap_ovf   (wrap_ovf),
    .seq_err    (seq_err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic is, input logic wp,
    input int wc, input logic wo,
    input logic se, input logic es,
    input int ec
  );
    exp_t e;
    e.is = is; e.wp = wp; e.wc = 8'(wc);
    e.wo = wo; e.se = se; e.es = es;
    e.ec = 8'(ec);
    return e;
  endfunction

  task automatic step(
    input logic rst, input logic en,
    input logic clr, input int in,
    input exp_t e, input string nm
  );
    reset    = rst;
    count_en = en;
    clr_err  = clr;
    count_in = 8'(in);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // monitor: one registered result per clock, checked at negedge
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = '{in_sync, wrap_pulse, wrap_cnt,
               wrap_ovf, seq_err, err_sticky,
               err_cnt};
        n_chk++;
        if (a === e)
          n_pass++;
        else
          $display(
            "FAIL %s: got is=%b wp=%b wc=%0d wo=%b se=%b es=%b ec=%0d want is=%b wp=%b wc=%0d wo=%b se=%b es=%b ec=%0d",
            nm, a.is, a.wp, a.wc, a.wo, a.se,
            a.es, a.ec, e.is, e.wp, e.wc, e.wo,
            e.se, e.es, e.ec);
      end
    end
  end

  initial begin
    int wc;
    int ec;
    reset = 1'b1; count_en = 1'b0;
    clr_err = 1'b0; count_in = '0;

    // basic tracking and one wrap
    step(1, 0, 0, 0, mk(0,0,0,0,0,0,0), "rst0");
    for (int i = 0; i <= 6; i++)
      step(0, 1, 0, i, mk(1,0,0,0,0,0,0),
           $sformatf("trk%0d", i));
    step(0, 1, 0, 0, mk(1,1,1,0,0,0,0), "wrap0");
    step(0, 1, 0, 1, mk(1,0,1,0,0,0,0), "post1");

    // mismatch at exp=3, recovery without wrap
    step(0, 1, 0, 2, mk(1,0,1,0,0,0,0), "trk2");
    step(0, 1, 0, 5, mk(0,0,1,0,1,1,1), "mis5");
    step(0, 1, 0, 6, mk(0,0,1,0,0,1,1), "flt6");
    step(0, 1, 0, 0, mk(1,0,1,0,0,1,1), "flt0");
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 5, mk(1,0,1,0,0,1,1),
           $sformatf("hold%0d", i));

    // build err_cnt to 4, then clear with concurrent error
    step(0, 1, 0, 3, mk(0,0,1,0,1,1,2), "e2");
    step(0, 1, 0, 0, mk(1,0,1,0,0,1,2), "r2");
    step(0, 1, 0, 4, mk(0,0,1,0,1,1,3), "e3");
    step(0, 1, 0, 0, mk(1,0,1,0,0,1,3), "r3");
    step(0, 1, 0, 2, mk(0,0,1,0,1,1,4), "e4");
    step(0, 1, 0, 0, mk(1,0,1,0,0,1,4), "r4");
    step(0, 1, 1, 5, mk(0,0,1,0,1,1,1), "clr_err");
    step(0, 0, 1, 5, mk(0,0,1,0,0,0,0), "clr_only");

    // out-of-range from IDLE, no recount in FAULT
    step(1, 1, 1, 3, mk(0,0,0,0,0,0,0), "rst1");
    step(0, 1, 0, 9, mk(0,0,0,0,1,1,1), "oor9");
    step(0, 1, 0, 3, mk(0,0,0,0,0,1,1), "flt3");
    step(0, 1, 0, 4, mk(0,0,0,0,0,1,1), "flt4");
    step(0, 1, 0, 0, mk(1,0,0,0,0,1,1), "flt_0");

    // reset mid-sequence at count 4 with wrap_cnt=2
    step(1, 0, 0, 0, mk(0,0,0,0,0,0,0), "rst2");
    for (int i = 0; i <= 17; i++)
      step(0, 1, 0, i % 7,
           mk(1, (i > 0 && i % 7 == 0), i / 7,
              0, 0, 0, 0),
           $sformatf("seq%0d", i));
    step(1, 1, 0, 4, mk(0,0,0,0,0,0,0), "rst_mid");
    step(0, 1, 0, 4, mk(0,0,0,0,0,0,0), "idle4");
    step(0, 1, 0, 0, mk(1,0,0,0,0,0,0), "idle0");

    // 256 wraps roll wrap_cnt and set wrap_ovf
    step(1, 0, 0, 0, mk(0,0,0,0,0,0,0), "rst3");
    for (int i = 0; i <= 256 * 7; i++) begin
      if (i == 1000)
        for (int k = 0; k < 3; k++)
          step(0, 0, 0, 0,
               mk(1, 0, (999 / 7) % 256, 0, 0, 0, 0),
               $sformatf("en_lo%0d", k));
      step(0, 1, 0, i % 7,
           mk(1, (i > 0 && i % 7 == 0),
              (i / 7) % 256, (i >= 256 * 7),
              0, 0, 0),
           $sformatf("ovf%0d", i));
    end

    // err_cnt saturates at 255
    step(1, 0, 0, 0, mk(0,0,0,0,0,0,0), "rst4");
    for (int k = 0; k < 260; k++) begin
      ec = (k > 255) ? 255 : k;
      step(0, 1, 0, 0, mk(1,0,0,0,0,(k > 0),ec),
           $sformatf("sat_r%0d", k));
      wc = (k + 1 > 255) ? 255 : k + 1;
      step(0, 1, 0, 9, mk(0,0,0,0,1,1,wc),
           $sformatf("sat_e%0d", k));
    end

    count_en = 1'b0;
    for (int t = 0; t < 10 && exp_q.size() > 0; t++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending want 0",
               exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
